sdrc_req_arbiter: RTL and testbench
===================================

Name: sdrc_req_arbiter

Overview:
- Round-robin arbiter that shares the single SDRAM controller application request port between NREQ requesters (e.g. DMA, CPU bridge, video fetch).
- Forwards the winner's address, length and direction, and steers write data beats from that requester.
- Routes returning read beats to the issuing requester through an in-order outstanding-read FIFO.
- Sits between the requesters and the controller core, in the Wishbone clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 26, address width
- DW, 32, data width
- BL, 5, burst length field width
- RD_DEPTH, 4, max outstanding read bursts (power of 2)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- req_i  in  NREQ  per-requester request; held until matching req_ack_o
- req_addr_i  in  NREQ*AW  packed addresses, requester k at [k*AW +: AW]
- req_len_i  in  NREQ*BL  burst length in words; 0 treated as 1
- req_wr_n_i  in  NREQ  0=write, 1=read
- req_ack_o  out  NREQ  one-hot acceptance strobe
- wr_data_i  in  NREQ*DW  packed write data
- wr_next_o  out  NREQ  advance-write-data strobe to granted writer
- rd_valid_o  out  NREQ  one-hot read beat valid
- rd_data_o  out  DW  read data (broadcast)
- app_req_o  out  1  request to controller
- app_req_addr_o  out  AW
- app_req_len_o  out  BL
- app_req_wr_n_o  out  1
- app_req_ack_i  in  1  controller accepted request
- app_wr_data_o  out  DW
- app_wr_next_req_i  in  1  controller consumes one write beat
- app_rd_valid_i  in  1
- app_rd_data_i  in  DW
- rd_outstanding_o  out  clog2(RD_DEPTH)+1  bursts in FIFO
- err_o  out  1  sticky: read beat with empty FIFO

Behaviour:
- Reset values: app_req_o=0, app_req_addr_o=0, app_req_len_o=0, app_req_wr_n_o=1, err_o=0, rd_outstanding_o=0. FSM=IDLE, FIFO empty, RR pointer=NREQ-1, so requester 0 has highest priority first.
- Reset asserted mid-operation aborts everything immediately; no strobes are issued afterwards.
- FSM states: IDLE, REQ, WDATA.
- IDLE:
  - eligible[k] = req_i[k] & ~(req_wr_n_i[k] & fifo_full).
  - Winner g is the first eligible index after the RR pointer, wrapping.
  - If any requester is eligible: register g and its addr/len/wr_n (len 0 becomes 1), then go to REQ.
  - app_req_o rises the cycle after req_i is sampled.
- REQ:
  - app_req_o=1 with the registered fields, held stable until ack.
  - req_ack_o[g] = app_req_ack_i (combinational). The requester drops req_i at the next edge.
  - On ack: RR pointer <= g and app_req_o <= 0.
  - Read: push {g,len} into FIFO, go to IDLE.
  - Write: clear beat counter, go to WDATA.
- WDATA:
  - app_wr_data_o = wr_data_i[g] (combinational mux; the mux holds g in all states).
  - wr_next_o[g] = app_wr_next_req_i.
  - Each strobe increments the beat count. The strobe on beat len-1 moves the FSM to IDLE.
  - No new request is granted until the write data phase is complete.
- Read return:
  - rd_data_o = app_rd_data_i.
  - rd_valid_o[head.id] = app_rd_valid_i & ~fifo_empty.
  - A read beat counter counts beats; the beat equal to head.len-1 pops the head and clears the counter.
  - app_rd_valid_i with an empty FIFO: beat dropped, err_o set until reset.
- FIFO:
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - When full, reads are ineligible but writes are still granted.
  - A read whose last beat frees an entry makes a blocked read eligible in the next IDLE evaluation.
  - Pointers wrap modulo RD_DEPTH.
- Reads and write data may overlap. The read return path is independent of the FSM.

Test Plan:
1. Req0 read addr=0x100 len=4; ack 2 cycles later; 4 rd_valid beats → app_req_o high cycle after req; req_ack_o=0001 with ack; rd_valid_o=0001 ×4, data passed through; rd_outstanding 1→0.
2. Req1 write len=3, app_wr_next_req_i pulses with gaps → wr_next_o=0010 exactly 3 times; app_wr_data_o tracks wr_data_i[1]; FSM IDLE after third pulse.
3. All 4 requesters reading continuously, immediate ack → grant order 0,1,2,3,0; no requester granted twice before the others.
4. RD_DEPTH=4 reads outstanding, req2 read plus req3 write pending → req3 write granted, req2 held. After the first burst's last beat, req2 is granted.
5. Read bursts to req0 (len 2) then req3 (len 1), returned back-to-back → rd_valid_o = 0001,0001,1000.
6. app_rd_valid_i with FIFO empty → err_o=1 until reset. wb_rst_i asserted mid-write → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sdrc_req_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller request port between NREQ
// requesters; steers write beats and routes read beats via an in-order FIFO.
module sdrc_req_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 26,
    parameter int DW       = 32,
    parameter int BL       = 5,
    parameter int RD_DEPTH = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ*AW-1:0]        req_addr_i,
    input  logic [NREQ*BL-1:0]        req_len_i,
    input  logic [NREQ-1:0]           req_wr_n_i,
    output logic [NREQ-1:0]           req_ack_o,
    input  logic [NREQ*DW-1:0]        wr_data_i,
    output logic [NREQ-1:0]           wr_next_o,
    output logic [NREQ-1:0]           rd_valid_o,
    output logic [DW-1:0]             rd_data_o,
    output logic                      app_req_o,
    output logic [AW-1:0]             app_req_addr_o,
    output logic [BL-1:0]             app_req_len_o,
    output logic                      app_req_wr_n_o,
    input  logic                      app_req_ack_i,
    output logic [DW-1:0]             app_wr_data_o,
    input  logic                      app_wr_next_req_i,
    input  logic                      app_rd_valid_i,
    input  logic [DW-1:0]             app_rd_data_i,
    output logic [$clog2(RD_DEPTH):0] rd_outstanding_o,
    output logic                      err_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int CW = $clog2(RD_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WDATA} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_gnt;
    logic [IW-1:0]   r_rr;
    logic            r_app_req;
    logic [AW-1:0]   r_addr;
    logic [BL-1:0]   r_len;
    logic            r_wr_n;
    logic [BL-1:0]   r_wbeat;

    logic [IW-1:0]   r_fifo_id  [RD_DEPTH];
    logic [BL-1:0]   r_fifo_len [RD_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_cnt;
    logic [BL-1:0]   r_rbeat;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic [NREQ-1:0] w_elig;
    logic            w_any;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic [AW-1:0]   w_sel_addr;
    logic [BL-1:0]   w_sel_len;
    logic            w_sel_wr_n;
    logic [IW-1:0]   w_head_id;
    logic [BL-1:0]   w_head_len;
    logic            w_rd_beat;
    logic            w_push;
    logic            w_pop;

    assign w_full     = (r_cnt == CW'(RD_DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign w_elig     = req_i & ~(req_wr_n_i & {NREQ{w_full}});
    assign w_head_id  = r_fifo_id[r_rptr];
    assign w_head_len = r_fifo_len[r_rptr];
    assign w_rd_beat  = app_rd_valid_i & ~w_empty;
    assign w_push     = (r_state == REQ) & app_req_ack_i & r_wr_n;
    assign w_pop      = w_rd_beat & (r_rbeat == w_head_len - BL'(1));

    // First eligible requester strictly after the round-robin pointer, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = IW'((32'(r_rr) + i) % NREQ);
            if (!w_any && w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_sel_wr_n = 1'b1;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_win == IW'(k)) begin
                w_sel_addr = req_addr_i[k*AW +: AW];
                w_sel_len  = req_len_i[k*BL +: BL];
                w_sel_wr_n = req_wr_n_i[k];
            end
        end
        if (w_sel_len == '0) begin
            w_sel_len = BL'(1);
        end
    end

    always_comb begin
        req_ack_o     = '0;
        wr_next_o     = '0;
        rd_valid_o    = '0;
        app_wr_data_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (r_gnt == IW'(k)) begin
                req_ack_o[k]  = (r_state == REQ) & app_req_ack_i;
                wr_next_o[k]  = (r_state == WDATA) & app_wr_next_req_i;
                app_wr_data_o = wr_data_i[k*DW +: DW];
            end
            if (w_head_id == IW'(k)) begin
                rd_valid_o[k] = w_rd_beat;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_rr      <= IW'(NREQ - 1);
            r_app_req <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_wr_n    <= 1'b1;
            r_wbeat   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt     <= w_win;
                        r_addr    <= w_sel_addr;
                        r_len     <= w_sel_len;
                        r_wr_n    <= w_sel_wr_n;
                        r_app_req <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (app_req_ack_i) begin
                        r_rr      <= r_gnt;
                        r_app_req <= 1'b0;
                        r_wbeat   <= '0;
                        r_state   <= r_wr_n ? IDLE : WDATA;
                    end
                end
                WDATA: begin
                    if (app_wr_next_req_i) begin
                        r_wbeat <= r_wbeat + BL'(1);
                        if (r_wbeat == r_len - BL'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_fifo_id[r_wptr]  <= r_gnt;
            r_fifo_len[r_wptr] <= r_len;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_rbeat <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PW'(RD_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(RD_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_rd_beat) begin
                r_rbeat <= w_pop ? '0 : r_rbeat + BL'(1);
            end
            // A beat with nothing outstanding is dropped and flagged until reset.
            if (app_rd_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign app_req_o        = r_app_req;
    assign app_req_addr_o   = r_addr;
    assign app_req_len_o    = r_len;
    assign app_req_wr_n_o   = r_wr_n;
    assign rd_data_o        = app_rd_data_i;
    assign rd_outstanding_o = r_cnt;
    assign err_o            = r_err;

endmodule

// File: tb/tb_sdrc_req_arbiter.sv
// Directed self-checking bench for sdrc_req_arbiter with default parameters.
module tb_sdrc_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int BL   = 5;

    logic                 clk;
    logic                 wb_rst_i;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*AW-1:0]   req_addr_i;
    logic [NREQ*BL-1:0]   req_len_i;
    logic [NREQ-1:0]      req_wr_n_i;
    logic [NREQ-1:0]      req_ack_o;
    logic [NREQ*DW-1:0]   wr_data_i;
    logic [NREQ-1:0]      wr_next_o;
    logic [NREQ-1:0]      rd_valid_o;
    logic [DW-1:0]        rd_data_o;
    logic                 app_req_o;
    logic [AW-1:0]        app_req_addr_o;
    logic [BL-1:0]        app_req_len_o;
    logic                 app_req_wr_n_o;
    logic                 app_req_ack_i;
    logic [DW-1:0]        app_wr_data_o;
    logic                 app_wr_next_req_i;
    logic                 app_rd_valid_i;
    logic [DW-1:0]        app_rd_data_i;
    logic [2:0]           rd_outstanding_o;
    logic                 err_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    sdrc_req_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .BL(BL), .RD_DEPTH(4)
    ) u_dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (wb_rst_i),
        .req_i             (req_i),
        .req_addr_i        (req_addr_i),
        .req_len_i         (req_len_i),
        .req_wr_n_i        (req_wr_n_i),
        .req_ack_o         (req_ack_o),
        .wr_data_i         (wr_data_i),
        .wr_next_o         (wr_next_o),
        .rd_valid_o        (rd_valid_o),
        .rd_data_o         (rd_data_o),
        .app_req_o         (app_req_o),
        .app_req_addr_o    (app_req_addr_o),
        .app_req_len_o     (app_req_len_o),
        .app_req_wr_n_o    (app_req_wr_n_o),
        .app_req_ack_i     (app_req_ack_i),
        .app_wr_data_o     (app_wr_data_o),
        .app_wr_next_req_i (app_wr_next_req_i),
        .app_rd_valid_i    (app_rd_valid_i),
        .app_rd_data_i     (app_rd_data_i),
        .rd_outstanding_o  (rd_outstanding_o),
        .err_o             (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_i             = '0;
        req_wr_n_i        = '1;
        app_req_ack_i     = 1'b0;
        app_wr_next_req_i = 1'b0;
        app_rd_valid_i    = 1'b0;
        wb_rst_i          = 1'b1;
        step();
        step();
        wb_rst_i = 1'b0;
    endtask

    task automatic issue(input int unsigned k, input logic [AW-1:0] addr, input logic [BL-1:0] len,
                         input logic wr_n, input int unsigned dly, output int unsigned lat);
        int unsigned n;
        logic [BL-1:0] elen;
        elen = (len == '0) ? BL'(1) : len;
        req_addr_i[k*AW +: AW] = addr;
        req_len_i[k*BL +: BL]  = len;
        req_wr_n_i[k]          = wr_n;
        req_i[k]               = 1'b1;
        n = 0;
        while (!app_req_o && n < 20) begin
            step();
            n++;
        end
        lat = n;
        chk("req_seen", app_req_o, 1);
        chk("req_addr", app_req_addr_o, addr);
        chk("req_len", app_req_len_o, elen);
        chk("req_wr_n", app_req_wr_n_o, wr_n);
        for (int unsigned d = 0; d < dly; d++) begin
            step();
            chk("req_hold", {app_req_o, req_ack_o}, {1'b1, 4'b0000});
        end
        app_req_ack_i = 1'b1;
        #1;
        chk("req_ack", req_ack_o, 64'(1) << k);
        step();
        app_req_ack_i = 1'b0;
        req_i[k]      = 1'b0;
        chk("req_drop", app_req_o, 0);
    endtask

    task automatic rd_beat(input logic [NREQ-1:0] exp, input logic [DW-1:0] d);
        app_rd_valid_i = 1'b1;
        app_rd_data_i  = d;
        #1;
        chk("rd_valid", rd_valid_o, exp);
        chk("rd_data", rd_data_o, d);
        step();
        app_rd_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        int unsigned gl [5];
        int unsigned t3_exp [5];
        int unsigned ng;
        int unsigned n;
        logic [5:0] pat;

        t3_exp = '{0, 1, 2, 3, 0};
        req_addr_i        = '0;
        req_len_i         = '0;
        wr_data_i         = '0;
        app_rd_data_i     = '0;
        req_i             = '0;
        req_wr_n_i        = '1;
        app_req_ack_i     = 1'b0;
        app_wr_next_req_i = 1'b0;
        app_rd_valid_i    = 1'b0;
        wb_rst_i          = 1'b1;
        #2;
        chk("rst_app_req", app_req_o, 0);
        chk("rst_addr", app_req_addr_o, 0);
        chk("rst_len", app_req_len_o, 0);
        chk("rst_wr_n", app_req_wr_n_o, 1);
        chk("rst_err", err_o, 0);
        chk("rst_outst", rd_outstanding_o, 0);
        chk("rst_ack", req_ack_o, 0);
        do_reset();

        // 1: single read from requester 0, ack after two extra cycles, four beats
        chk("t1_req_pre", app_req_o, 0);
        issue(0, 26'h100, 5'd4, 1'b1, 2, lat);
        chk("t1_latency", lat, 1);
        chk("t1_outst1", rd_outstanding_o, 1);
        for (int unsigned b = 0; b < 4; b++) begin
            rd_beat(4'b0001, 32'hA000_0000 + b);
            chk("t1_outst", rd_outstanding_o, (b == 3) ? 0 : 1);
        end

        // 2: write from requester 1 with gapped beat strobes; req0 waits meanwhile
        issue(1, 26'h2000, 5'd3, 1'b0, 0, lat);
        pat = 6'b101001;
        for (int unsigned c = 0; c < 6; c++) begin
            app_wr_next_req_i = pat[c];
            wr_data_i[DW +: DW] = 32'hD100_0000 + c;
            if (c == 1) begin
                req_addr_i[0 +: AW] = 26'h400;
                req_len_i[0 +: BL]  = 5'd1;
                req_wr_n_i[0]       = 1'b1;
                req_i[0]            = 1'b1;
            end
            #1;
            chk("t2_wdata", app_wr_data_o, 32'hD100_0000 + c);
            chk("t2_wr_next", wr_next_o, pat[c] ? 4'b0010 : 4'b0000);
            chk("t2_no_grant", app_req_o, 0);
            step();
        end
        app_wr_next_req_i = 1'b1;
        #1;
        chk("t2_post_next", wr_next_o, 0);
        chk("t2_post_req", app_req_o, 0);
        step();
        app_wr_next_req_i = 1'b0;
        chk("t2_req0_up", app_req_o, 1);
        chk("t2_req0_addr", app_req_addr_o, 26'h400);
        app_req_ack_i = 1'b1;
        #1;
        chk("t2_req0_ack", req_ack_o, 4'b0001);
        step();
        app_req_ack_i = 1'b0;
        req_i[0]      = 1'b0;
        rd_beat(4'b0001, 32'h5555_AAAA);
        chk("t2_outst", rd_outstanding_o, 0);

        // 3: all requesters reading continuously with immediate ack
        do_reset();
        for (int unsigned k = 0; k < NREQ; k++) begin
            req_addr_i[k*AW +: AW] = AW'(32'h1000 * (k + 1));
            req_len_i[k*BL +: BL]  = 5'd1;
        end
        req_wr_n_i = '1;
        req_i      = '1;
        gl = '{default: 99};
        ng = 0;
        for (int unsigned cyc = 0; cyc < 40 && ng < 5; cyc++) begin
            app_req_ack_i  = app_req_o;
            app_rd_valid_i = (rd_outstanding_o != 0);
            app_rd_data_i  = 32'hC0DE_0000 + cyc;
            #1;
            if (req_ack_o != '0) begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    if (req_ack_o[k]) gl[ng] = k;
                end
                ng++;
            end
            step();
        end
        req_i         = '0;
        app_req_ack_i = 1'b0;
        chk("t3_grants", ng, 5);
        for (int unsigned i = 0; i < 5; i++) begin
            chk("t3_order", gl[i], t3_exp[i]);
        end
        n = 0;
        while (rd_outstanding_o != 0 && n < 20) begin
            app_rd_valid_i = 1'b1;
            step();
            n++;
        end
        app_rd_valid_i = 1'b0;
        chk("t3_drained", rd_outstanding_o, 0);
        chk("t3_err", err_o, 0);

        // 4: FIFO full blocks a read but not a write; a freed slot admits the read
        do_reset();
        for (int unsigned i = 0; i < 4; i++) begin
            issue(0, AW'(32'h800 + i), 5'd2, 1'b1, 0, lat);
        end
        chk("t4_full", rd_outstanding_o, 4);
        req_addr_i[2*AW +: AW] = 26'h2200;
        req_len_i[2*BL +: BL]  = 5'd1;
        req_wr_n_i[2]          = 1'b1;
        req_i[2]               = 1'b1;
        issue(3, 26'h3300, 5'd1, 1'b0, 0, lat);
        app_wr_next_req_i = 1'b1;
        #1;
        chk("t4_wr_next", wr_next_o, 4'b1000);
        step();
        app_wr_next_req_i = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("t4_blocked", app_req_o, 0);
        end
        rd_beat(4'b0001, 32'h0000_1111);
        rd_beat(4'b0001, 32'h0000_2222);
        chk("t4_freed_lat", app_req_o, 0);
        chk("t4_outst3", rd_outstanding_o, 3);
        step();
        chk("t4_req2_up", app_req_o, 1);
        chk("t4_req2_addr", app_req_addr_o, 26'h2200);
        app_req_ack_i = 1'b1;
        #1;
        chk("t4_req2_ack", req_ack_o, 4'b0100);
        step();
        app_req_ack_i = 1'b0;
        req_i[2]      = 1'b0;
        chk("t4_refull", rd_outstanding_o, 4);
        for (int unsigned i = 0; i < 6; i++) begin
            rd_beat(4'b0001, 32'hBEEF_0000 + i);
        end
        rd_beat(4'b0100, 32'hBEEF_0100);
        chk("t4_empty", rd_outstanding_o, 0);

        // 5: back-to-back returns to two requesters; length 0 forwarded as 1
        issue(0, 26'h500, 5'd2, 1'b1, 0, lat);
        issue(3, 26'h600, 5'd0, 1'b1, 1, lat);
        chk("t5_outst", rd_outstanding_o, 2);
        rd_beat(4'b0001, 32'h1234_5678);
        rd_beat(4'b0001, 32'h9ABC_DEF0);
        rd_beat(4'b1000, 32'h0F0F_0F0F);
        chk("t5_empty", rd_outstanding_o, 0);
        chk("t5_err", err_o, 0);

        // 6: stray read beat sets sticky error; reset mid-write clears everything
        app_rd_valid_i = 1'b1;
        #1;
        chk("t6_stray_valid", rd_valid_o, 0);
        step();
        app_rd_valid_i = 1'b0;
        chk("t6_err_set", err_o, 1);
        step();
        step();
        chk("t6_err_sticky", err_o, 1);
        issue(1, 26'h700, 5'd4, 1'b0, 0, lat);
        app_wr_next_req_i = 1'b1;
        #1;
        chk("t6_beat0", wr_next_o, 4'b0010);
        step();
        #1;
        chk("t6_pre_rst", wr_next_o, 4'b0010);
        wb_rst_i = 1'b1;
        #1;
        chk("t6_rst_next", wr_next_o, 0);
        chk("t6_rst_req", app_req_o, 0);
        chk("t6_rst_addr", app_req_addr_o, 0);
        chk("t6_rst_len", app_req_len_o, 0);
        chk("t6_rst_wr_n", app_req_wr_n_o, 1);
        chk("t6_rst_err", err_o, 0);
        chk("t6_rst_outst", rd_outstanding_o, 0);
        step();
        step();
        wb_rst_i = 1'b0;
        #1;
        chk("t6_no_strobe", wr_next_o, 0);
        step();
        chk("t6_idle_req", app_req_o, 0);
        app_wr_next_req_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
